// File: rtl/data_sampler_ctrl.sv
// data_sampler_ctrl: clears the sampler FIFO, optionally waits for trigger + delay,
// gates DATA_VALID_IN into the FIFO write for SAMPLE_LEN words, then waits for drain.
module data_sampler_ctrl #(
  parameter int CNT_WIDTH  = 16,
  parameter int CLR_CYCLES = 8
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic [CNT_WIDTH-1:0] SAMPLE_LEN,
  input  logic                 TRIG_EN,
  input  logic [CNT_WIDTH-1:0] TRIG_DELAY,
  input  logic                 TRIG_IN,
  input  logic                 DATA_VALID_IN,
  input  logic                 FIFO_FULL,
  input  logic                 FIFO_EMPTY,
  output logic                 FIFO_RESET,
  output logic                 SAMPLE_EN,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 OVERFLOW,
  output logic [CNT_WIDTH-1:0] WORD_CNT
);
  localparam int CW = $clog2(CLR_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, CLEAR, WAIT_TRIG, DELAY, CAPTURE, DRAIN} state_t;
  state_t state, state_n, after_trig;
  logic [CNT_WIDTH-1:0] len_q, dly_q, dly_cnt, word_cnt;
  logic [CW-1:0] clr_cnt;
  logic trig_en_q, trig_prev, done, overflow, fifo_reset;
  logic trig_edge, clr_last, last_word, accept;
  assign trig_edge  = TRIG_IN & ~trig_prev;
  assign clr_last   = clr_cnt == CW'(CLR_CYCLES - 1);
  assign last_word  = word_cnt + CNT_WIDTH'(1) == len_q;
  assign after_trig = dly_q != '0 ? DELAY : CAPTURE;
  assign accept     = START & ~ABORT & (state == IDLE);
  // Zero-latency gate keeps DIN and DIN_VALID aligned at the sampler
  assign SAMPLE_EN  = DATA_VALID_IN & ~FIFO_FULL & ~ABORT & (state == CAPTURE);
  assign FIFO_RESET = fifo_reset;
  assign BUSY       = state != IDLE;
  assign DONE       = done;
  assign OVERFLOW   = overflow;
  assign WORD_CNT   = word_cnt;
  always_comb begin
    state_n = state;
    if (ABORT) state_n = IDLE;
    else
      case (state)
        IDLE:      if (START) state_n = CLEAR;
        CLEAR:     if (clr_last) state_n = len_q == '0 ? IDLE : trig_en_q ? WAIT_TRIG : after_trig;
        WAIT_TRIG: if (trig_edge) state_n = after_trig;
        DELAY:     if (dly_cnt <= CNT_WIDTH'(1)) state_n = CAPTURE;
        CAPTURE:   if (SAMPLE_EN && last_word) state_n = DRAIN;
        DRAIN:     if (FIFO_EMPTY) state_n = IDLE;
        default:   state_n = IDLE;
      endcase
  end
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state      <= IDLE;
      trig_prev  <= 1'b0;
      fifo_reset <= 1'b0;
      clr_cnt    <= '0;
      dly_cnt    <= '0;
      len_q      <= '0;
      dly_q      <= '0;
      trig_en_q  <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      word_cnt   <= '0;
    end else begin
      state      <= state_n;
      trig_prev  <= TRIG_IN;
      fifo_reset <= state_n == CLEAR;
      clr_cnt    <= state == CLEAR ? clr_cnt + CW'(1) : '0;
      dly_cnt    <= state == DELAY ? dly_cnt - CNT_WIDTH'(1) : dly_q;
      if (accept) begin
        len_q     <= SAMPLE_LEN;
        dly_q     <= TRIG_DELAY;
        trig_en_q <= TRIG_EN;
        done      <= 1'b0;
        overflow  <= 1'b0;
        word_cnt  <= '0;
      end
      if (SAMPLE_EN) word_cnt <= word_cnt + CNT_WIDTH'(1);
      if (state == CAPTURE && DATA_VALID_IN && FIFO_FULL && !ABORT) overflow <= 1'b1;
      // Normal completion only; an abort lands in IDLE without DONE
      if (state != IDLE && state_n == IDLE && !ABORT) done <= 1'b1;
    end
  end
endmodule

// File: tb/tb_data_sampler_ctrl.sv
// tb_data_sampler_ctrl: directed bench; each word expected to be written is queued
// when driven and popped when SAMPLE_EN fires, so timing and count are both checked.
module tb_data_sampler_ctrl;
  localparam int W = 16;
  logic CLK = 0, RESET_N = 0, START = 0, ABORT = 0, TRIG_EN = 0, TRIG_IN = 0;
  logic DATA_VALID_IN = 0, FIFO_FULL = 0, FIFO_EMPTY = 1;
  logic [W-1:0] SAMPLE_LEN = '0, TRIG_DELAY = '0;
  logic FIFO_RESET, SAMPLE_EN, BUSY, DONE, OVERFLOW;
  logic [W-1:0] WORD_CNT;
  logic [15:0] din = '0;
  logic [15:0] sb[$];
  int n_chk = 0, n_fail = 0, pulses = 0, p0 = 0;

  data_sampler_ctrl #(.CNT_WIDTH(W), .CLR_CYCLES(8)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .ABORT(ABORT),
    .SAMPLE_LEN(SAMPLE_LEN), .TRIG_EN(TRIG_EN), .TRIG_DELAY(TRIG_DELAY),
    .TRIG_IN(TRIG_IN), .DATA_VALID_IN(DATA_VALID_IN), .FIFO_FULL(FIFO_FULL),
    .FIFO_EMPTY(FIFO_EMPTY), .FIFO_RESET(FIFO_RESET), .SAMPLE_EN(SAMPLE_EN),
    .BUSY(BUSY), .DONE(DONE), .OVERFLOW(OVERFLOW), .WORD_CNT(WORD_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RESET_N && SAMPLE_EN === 1'b1) begin
      pulses++;
      n_chk++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_sample_en: observed pulse on word %0h expected none", din);
      end
      if (sb.size() != 0) chk("sample_word", 32'(din), 32'(sb.pop_front()));
    end
  end

  task automatic cyc(input logic v, input logic f, input logic acc);
    @(posedge CLK);
    #1;
    din++;
    DATA_VALID_IN = v;
    FIFO_FULL = f;
    if (acc) sb.push_back(din);
  endtask

  // Returns after the 8th CLEAR edge; config inputs are scrambled after START
  task automatic start_cap(input logic [W-1:0] len, input logic ten, input logic [W-1:0] dly, input logic v);
    cyc(v, 0, 0);
    START = 1; SAMPLE_LEN = len; TRIG_EN = ten; TRIG_DELAY = dly;
    cyc(v, 0, 0);
    START = 0; SAMPLE_LEN = '1; TRIG_EN = ~ten; TRIG_DELAY = '1;
    repeat (7) cyc(v, 0, 0);
  endtask

  initial begin
    repeat (3) cyc(0, 0, 0);
    chk("rst_fifo_reset", 32'(FIFO_RESET), 0);
    chk("rst_sample_en", 32'(SAMPLE_EN), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_done", 32'(DONE), 0);
    chk("rst_overflow", 32'(OVERFLOW), 0);
    chk("rst_word_cnt", 32'(WORD_CNT), 0);
    RESET_N = 1;
    cyc(0, 0, 0);
    START = 1; ABORT = 1; SAMPLE_LEN = 5;
    cyc(0, 0, 0);
    START = 0; ABORT = 0;
    chk("abort_beats_start_busy", 32'(BUSY), 0);
    chk("abort_beats_start_fifo_reset", 32'(FIFO_RESET), 0);

    // Untriggered capture of 5 words, then a 20-cycle drain wait
    FIFO_EMPTY = 0;
    cyc(1, 0, 0);
    START = 1; SAMPLE_LEN = 5; TRIG_EN = 0; TRIG_DELAY = 0;
    for (int k = 0; k < 8; k++) begin
      cyc(1, 0, 0);
      START = 0; SAMPLE_LEN = '1;
      chk("t1_fifo_reset_high", 32'(FIFO_RESET), 1);
    end
    p0 = pulses;
    for (int k = 0; k < 5; k++) begin
      cyc(1, 0, 1);
      chk("t1_fifo_reset_low", 32'(FIFO_RESET), 0);
    end
    for (int k = 0; k < 20; k++) begin
      cyc(1, 0, 0);
      chk("t1_drain_busy", 32'(BUSY), 1);
      chk("t1_drain_done", 32'(DONE), 0);
    end
    chk("t1_word_cnt", 32'(WORD_CNT), 5);
    FIFO_EMPTY = 1;
    cyc(0, 0, 0);
    chk("t1_done", 32'(DONE), 1);
    chk("t1_idle", 32'(BUSY), 0);
    chk("t1_pulses", 32'(pulses - p0), 5);
    chk("t1_sb_empty", 32'(sb.size()), 0);

    // Triggered with delay 3; initial high trigger ignored; START mid-capture ignored
    TRIG_IN = 1;
    start_cap(4, 1, 3, 1);
    repeat (5) cyc(1, 0, 0);
    chk("t2_wait_busy", 32'(BUSY), 1);
    chk("t2_wait_cnt", 32'(WORD_CNT), 0);
    cyc(1, 0, 0);
    TRIG_IN = 0;
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    TRIG_IN = 1;
    p0 = pulses;
    repeat (3) cyc(1, 0, 0);
    cyc(1, 0, 1);
    cyc(1, 0, 1);
    START = 1;
    cyc(1, 0, 1);
    START = 0;
    chk("t2_start_ignored", 32'(FIFO_RESET), 0);
    cyc(1, 0, 1);
    cyc(1, 0, 0);
    chk("t2_word_cnt", 32'(WORD_CNT), 4);
    cyc(1, 0, 0);
    chk("t2_done", 32'(DONE), 1);
    chk("t2_idle", 32'(BUSY), 0);
    chk("t2_pulses", 32'(pulses - p0), 4);
    chk("t2_sb_empty", 32'(sb.size()), 0);
    TRIG_IN = 0;

    // Gapped source with the 2nd valid word hitting a full FIFO
    start_cap(6, 0, 0, 0);
    p0 = pulses;
    for (int i = 0; i < 14; i++) begin
      cyc(i % 2 == 0, i == 2, i % 2 == 0 && i != 2);
      if (i == 3) chk("t3_overflow_set", 32'(OVERFLOW), 1);
    end
    chk("t3_overflow", 32'(OVERFLOW), 1);
    chk("t3_word_cnt", 32'(WORD_CNT), 6);
    cyc(1, 0, 0);
    chk("t3_done", 32'(DONE), 1);
    cyc(1, 0, 0);
    chk("t3_pulses", 32'(pulses - p0), 6);
    chk("t3_sb_empty", 32'(sb.size()), 0);

    // Zero-length capture
    p0 = pulses;
    start_cap(0, 0, 0, 1);
    chk("t4_done_cleared", 32'(DONE), 0);
    chk("t4_busy", 32'(BUSY), 1);
    cyc(1, 0, 0);
    chk("t4_done", 32'(DONE), 1);
    chk("t4_idle", 32'(BUSY), 0);
    chk("t4_word_cnt", 32'(WORD_CNT), 0);
    chk("t4_pulses", 32'(pulses - p0), 0);

    // Abort during DELAY
    start_cap(4, 0, 5, 1);
    cyc(1, 0, 0);
    chk("t5_delay_busy", 32'(BUSY), 1);
    cyc(1, 0, 0);
    ABORT = 1;
    cyc(1, 0, 0);
    ABORT = 0;
    chk("t5_abort_idle", 32'(BUSY), 0);
    chk("t5_abort_done", 32'(DONE), 0);
    chk("t5_abort_fifo_reset", 32'(FIFO_RESET), 0);
    chk("t5_word_cnt", 32'(WORD_CNT), 0);

    // Abort during CAPTURE after 2 words
    start_cap(5, 0, 0, 1);
    cyc(1, 0, 1);
    cyc(1, 0, 1);
    cyc(1, 0, 0);
    ABORT = 1;
    cyc(1, 0, 0);
    ABORT = 0;
    chk("t6_abort_idle", 32'(BUSY), 0);
    chk("t6_abort_done", 32'(DONE), 0);
    chk("t6_word_cnt", 32'(WORD_CNT), 2);
    cyc(1, 0, 0);
    chk("t6_word_cnt_held", 32'(WORD_CNT), 2);
    chk("t6_sb_empty", 32'(sb.size()), 0);

    // Reset mid-capture
    start_cap(5, 0, 0, 0);
    cyc(1, 1, 0);
    cyc(1, 0, 1);
    cyc(1, 0, 1);
    cyc(0, 0, 0);
    chk("t7_pre_overflow", 32'(OVERFLOW), 1);
    chk("t7_pre_word_cnt", 32'(WORD_CNT), 2);
    chk("t7_pre_busy", 32'(BUSY), 1);
    RESET_N = 0;
    cyc(1, 0, 0);
    chk("t7_fifo_reset", 32'(FIFO_RESET), 0);
    chk("t7_sample_en", 32'(SAMPLE_EN), 0);
    chk("t7_busy", 32'(BUSY), 0);
    chk("t7_done", 32'(DONE), 0);
    chk("t7_overflow", 32'(OVERFLOW), 0);
    chk("t7_word_cnt", 32'(WORD_CNT), 0);
    RESET_N = 1;
    cyc(0, 0, 0);
    chk("t7_sb_empty", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/data_sampler_ctrl.md
Name: data_sampler_ctrl

Overview:
Sequences snapshot captures into the data sampler FIFO. On a software start it clears the FIFO, optionally waits for a trigger plus a programmable delay, then gates the source valid strobe into the FIFO write enable for exactly SAMPLE_LEN accepted words. It then waits for readout to drain the FIFO and reports completion. Single clock domain: CLK also clocks the sampler's write side.

Parameters:
CNT_WIDTH, 16, width of SAMPLE_LEN, TRIG_DELAY and the word counter
CLR_CYCLES, 8, number of cycles FIFO_RESET is held high in CLEAR (>=1)

Ports:
CLK  input  1  system clock, all logic on rising edge
RESET_N  input  1  synchronous active-low reset
START  input  1  single-cycle pulse; begins a capture when IDLE
ABORT  input  1  forces return to IDLE from any state
SAMPLE_LEN  input  CNT_WIDTH  number of words to capture; latched at START
TRIG_EN  input  1  1: wait for TRIG_IN before capture; latched at START
TRIG_DELAY  input  CNT_WIDTH  cycles between trigger and capture; latched at START
TRIG_IN  input  1  trigger level; rising edge (registered compare) is the event
DATA_VALID_IN  input  1  source data strobe, aligned with sampler DIN
FIFO_FULL  input  1  sampler write-side full
FIFO_EMPTY  input  1  sampler readout-side empty (DOUT_EMPTY)
FIFO_RESET  output  1  clear to sampler FIFO, active high
SAMPLE_EN  output  1  drives sampler DIN_VALID
BUSY  output  1  high in any state other than IDLE
DONE  output  1  sticky completion flag
OVERFLOW  output  1  sticky; a valid word was dropped due to FIFO_FULL
WORD_CNT  output  CNT_WIDTH  words accepted in current/last capture

Behaviour:
- Reset (RESET_N low at clock edge): state IDLE; FIFO_RESET=0, SAMPLE_EN=0, BUSY=0, DONE=0, OVERFLOW=0, WORD_CNT=0, trigger edge register=0.
- States: IDLE, CLEAR, WAIT_TRIG, DELAY, CAPTURE, DRAIN.
- IDLE: START -> CLEAR. Latch SAMPLE_LEN, TRIG_EN, TRIG_DELAY; clear DONE, OVERFLOW, WORD_CNT. START in any other state is ignored.
- CLEAR: FIFO_RESET=1 (registered, asserted the cycle after START) for exactly CLR_CYCLES cycles. Then: if latched SAMPLE_LEN==0 -> IDLE with DONE=1. Else if TRIG_EN -> WAIT_TRIG. Else -> DELAY if TRIG_DELAY!=0, otherwise CAPTURE.
- WAIT_TRIG: rising edge of TRIG_IN (TRIG_IN=1 and previous-cycle TRIG_IN=0) -> DELAY if TRIG_DELAY!=0, else CAPTURE. A TRIG_IN already high on entry does not trigger; it must go low and then high again.
- DELAY: down-counter loaded with TRIG_DELAY on entry. Spends exactly TRIG_DELAY cycles, then goes to CAPTURE.
- CAPTURE: SAMPLE_EN = DATA_VALID_IN & ~FIFO_FULL & (state==CAPTURE). This is combinational, with zero latency, so DIN and DIN_VALID stay aligned.
  - Each SAMPLE_EN cycle increments WORD_CNT.
  - DATA_VALID_IN & FIFO_FULL in CAPTURE sets OVERFLOW. The word is dropped and not counted.
  - When the increment makes WORD_CNT==SAMPLE_LEN, go to DRAIN the next cycle. SAMPLE_EN can never exceed SAMPLE_LEN pulses.
- DRAIN: SAMPLE_EN=0. When FIFO_EMPTY=1, go to IDLE and set DONE=1 in the same edge.
- DONE stays high until the next accepted START or reset. WORD_CNT holds its final value in IDLE.
- ABORT (any non-IDLE state): next state IDLE, FIFO_RESET=0, SAMPLE_EN deasserts combinationally that cycle. DONE stays 0; OVERFLOW and WORD_CNT are retained.
- Priority: RESET_N > ABORT > normal transitions. START and ABORT in the same cycle while IDLE: ABORT wins, start is ignored.
- Reset mid-capture: immediate return to reset values. The sampler FIFO is not cleared by this block on reset; the next START's CLEAR phase does that.
- WORD_CNT never wraps, because SAMPLE_LEN <= 2^CNT_WIDTH-1.

Test Plan:
- Untriggered capture: TRIG_EN=0, TRIG_DELAY=0, SAMPLE_LEN=5, DATA_VALID_IN=1 constant -> FIFO_RESET high 8 cycles, then SAMPLE_EN high exactly 5 consecutive cycles, WORD_CNT=5, DONE=1 once FIFO_EMPTY=1.
- Triggered with delay: TRIG_EN=1, TRIG_DELAY=3, SAMPLE_LEN=4; TRIG_IN held high from START, later low then high -> no capture on the initial high; first SAMPLE_EN exactly 4 cycles after the rising-edge cycle; 4 pulses total.
- Gapped source and full: DATA_VALID_IN alternating 1/0, FIFO_FULL=1 on the 2nd valid -> that word is not enabled, OVERFLOW=1, and capture still ends after 6 accepted words for SAMPLE_LEN=6.
- Drain wait: capture done with FIFO_EMPTY=0 for 20 cycles -> BUSY=1 and DONE=0 throughout, DONE=1 on the edge after FIFO_EMPTY rises.
- Edge cases: SAMPLE_LEN=0 -> CLEAR then IDLE, DONE=1, zero SAMPLE_EN pulses. START during CAPTURE -> ignored, count unaffected.
- ABORT during DELAY and during CAPTURE (after 2 words) -> IDLE the next cycle, DONE=0, WORD_CNT=2 retained. RESET_N low mid-capture -> all outputs 0 at the next edge.
